// File: rtl/wb_dma.sv
// wb_dma: single-channel Wishbone word-copy DMA engine.
// A slave port exposes SRC/DST/LEN/CTRL. A master port copies LEN words
// from SRC to DST, doing one read and then one write per word, with a
// one-cycle bus release between words so the arbiter can re-arbitrate.
module wb_dma #(
  parameter int LENBITS = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [1:0]         sadr_i,
  input  logic [31:0]        sdat_i,
  output logic [31:0]        sdat_o,
  input  logic [3:0]         ssel_i,
  input  logic               swe_i,
  input  logic               sstb_i,
  output logic               sack_o,
  output logic [29:0]        madr_o,
  input  logic [31:0]        mdat_i,
  output logic [31:0]        mdat_o,
  output logic               mwe_o,
  output logic [3:0]         msel_o,
  output logic               mstb_o,
  input  logic               mack_i,
  output logic               mcyc_o,
  output logic               irq_o
);

  typedef enum logic [1:0] {IDLE, RD, WR, GAP} state_t;

  state_t               state, state_nxt;
  logic [31:0]          src, dst, buffer;
  logic [LENBITS-1:0]   len;
  logic                 ie, done, start_req, abort_pend;
  logic                 busy, slv_acc, slv_wr, cfg_wr, ctrl_wr;
  logic [31:0]          src_wr, dst_wr, rd_mux;
  logic [LENBITS-1:0]   len_wr;

  assign busy    = (state != IDLE);
  assign slv_acc = sstb_i & ~sack_o;
  assign slv_wr  = slv_acc & swe_i;
  assign cfg_wr  = slv_wr & ~busy;
  assign ctrl_wr = slv_wr & (sadr_i == 2'd3) & ssel_i[0];

  // Byte-lane merge of slave write data into the config registers.
  always_comb begin
    src_wr = src;
    dst_wr = dst;
    len_wr = len;
    for (int i = 0; i < 4; i++) begin
      if (ssel_i[i]) begin
        src_wr[8*i +: 8] = sdat_i[8*i +: 8];
        dst_wr[8*i +: 8] = sdat_i[8*i +: 8];
      end
    end
    for (int b = 0; b < LENBITS; b++) begin
      if (ssel_i[b/8]) len_wr[b] = sdat_i[b];
    end
    src_wr[1:0] = 2'b00;
    dst_wr[1:0] = 2'b00;
  end

  // Slave read mux; pointers and count are shown live.
  always_comb begin
    rd_mux = '0;
    case (sadr_i)
      2'd0:    rd_mux = src;
      2'd1:    rd_mux = dst;
      2'd2:    rd_mux = 32'(len);
      default: rd_mux = {28'd0, ie, done, busy, 1'b0};
    endcase
  end

  // Slave handshake: one wait state, single-cycle ack, registered read data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sack_o <= 1'b0;
      sdat_o <= '0;
    end else begin
      sack_o <= sstb_i & ~sack_o;
      if (slv_acc) sdat_o <= rd_mux;
    end
  end

  // Master state register; an async reset drops the bus request at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and master bus outputs decoded from the state.
  always_comb begin
    state_nxt = state;
    mcyc_o    = 1'b0;
    mstb_o    = 1'b0;
    mwe_o     = 1'b0;
    madr_o    = '0;
    mdat_o    = '0;
    msel_o    = 4'h0;
    case (state)
      IDLE: begin
        if (start_req && (len != '0)) state_nxt = RD;
      end
      RD: begin
        mcyc_o = 1'b1;
        mstb_o = 1'b1;
        madr_o = src[31:2];
        msel_o = 4'hF;
        if (mack_i) state_nxt = abort_pend ? GAP : WR;
      end
      WR: begin
        mcyc_o = 1'b1;
        mstb_o = 1'b1;
        mwe_o  = 1'b1;
        madr_o = dst[31:2];
        mdat_o = buffer;
        msel_o = 4'hF;
        if (mack_i) state_nxt = GAP;
      end
      default: begin
        state_nxt = (abort_pend || (len == '0)) ? IDLE : RD;
      end
    endcase
  end

  // Config registers, transfer progress, done/abort flags and interrupt.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src        <= '0;
      dst        <= '0;
      len        <= '0;
      buffer     <= '0;
      ie         <= 1'b0;
      done       <= 1'b0;
      start_req  <= 1'b0;
      abort_pend <= 1'b0;
      irq_o      <= 1'b0;
    end else begin
      start_req <= ctrl_wr & sdat_i[0];
      if (cfg_wr && (sadr_i == 2'd0)) src <= src_wr;
      if (cfg_wr && (sadr_i == 2'd1)) dst <= dst_wr;
      if (cfg_wr && (sadr_i == 2'd2)) len <= len_wr;
      if (state == RD && mack_i) buffer <= mdat_i;
      if (state == WR && mack_i) begin
        src <= src + 32'd4;
        dst <= dst + 32'd4;
        len <= len - LENBITS'(1);
      end
      if (ctrl_wr) begin
        ie <= sdat_i[3];
        if (sdat_i[2]) done <= 1'b0;
      end
      if (state == IDLE && start_req && (len == '0)) done <= 1'b1;
      if (state == GAP && (len == '0) && !abort_pend) done <= 1'b1;
      if (state == IDLE)                    abort_pend <= 1'b0;
      else if (ctrl_wr && sdat_i[4])        abort_pend <= 1'b1;
      irq_o <= done & ie;
    end
  end

endmodule
